// File: rtl/cla_pkg.sv
// ---------------------------------------------------------------------------
// cla_pkg
// Shared constants and types for the pipelined 8-bit CLA adder/subtractor.
//   DATA_W            datapath width (8)
//   FLAG_C/V/Z/N      bit positions inside the 4-bit flags word, C at bit 3
//   SAT_POS/SAT_NEG   signed saturation limits
//   s1_bundle_t       stage-1 register contents (propagate/generate vectors,
//                     carry-in, operand sign bits and, only when
//                     CLA_ADDSUB_SAT_EN is defined, the saturation request)
// ---------------------------------------------------------------------------
package cla_pkg;

  localparam int DATA_W = 8;

  localparam int FLAG_C = 3;
  localparam int FLAG_V = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_N = 0;

  localparam logic [7:0] SAT_POS = 8'h7F;
  localparam logic [7:0] SAT_NEG = 8'h80;

  typedef struct packed {
    logic [DATA_W-1:0] p;
    logic [DATA_W-1:0] g;
    logic              c0;
    logic              a_msb;
    logic              b_msb;
`ifdef CLA_ADDSUB_SAT_EN
    logic              sat;
`endif
  } s1_bundle_t;

endpackage

// File: rtl/cla8_carry.sv
// ---------------------------------------------------------------------------
// cla8_carry
// Combinational two-level carry lookahead for an 8-bit adder.
//   p  [7:0]  in   propagate vector (a ^ b_eff)
//   g  [7:0]  in   generate vector  (a & b_eff)
//   c0        in   carry into bit 0
//   c  [8:1]  out  carry into bit i (c[8] is the carry out)
// Each c[i] is built as a flat sum of products directly from p/g/c0:
//   c[i] = g[i-1] | p[i-1]g[i-2] | ... | p[i-1]..p[0]c0
// so no carry depends on a previously computed carry.
// ---------------------------------------------------------------------------
module cla8_carry
  import cla_pkg::*;
(
  input  logic [DATA_W-1:0] p,
  input  logic [DATA_W-1:0] g,
  input  logic              c0,
  output logic [DATA_W:1]   c
);

  // Flat AND-OR expansion of every carry from the propagate/generate terms.
  always_comb begin
    logic acc;
    logic term;
    c = {DATA_W{1'b0}};
    for (int i = 1; i <= DATA_W; i++) begin
      acc = 1'b0;
      // Generate at bit j, propagated through bits j+1 .. i-1.
      for (int j = 0; j < i; j++) begin
        term = g[j];
        for (int k = j + 1; k < i; k++) begin
          term = term & p[k];
        end
        acc = acc | term;
      end
      // Carry-in propagated through bits 0 .. i-1.
      term = c0;
      for (int k = 0; k < i; k++) begin
        term = term & p[k];
      end
      c[i] = acc | term;
    end
  end

endmodule

// File: rtl/cla_addsub_pipe.sv
// ---------------------------------------------------------------------------
// cla_addsub_pipe
// Two-stage pipelined 8-bit adder/subtractor with valid/ready handshakes.
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   input handshake; in_ready depends only on state and
//                       out_ready, never on in_valid
//   a, b [7:0]          operands
//   cin                 carry-in (add only)
//   sub                 0: a + b + cin, 1: a - b
//   sat                 signed saturation request (CLA_ADDSUB_SAT_EN only)
//   out_valid/out_ready output handshake
//   sum [7:0]           result
//   flags [3:0]         {C, V, Z, N}; for subtract C = 1 means no borrow
// Stage 1 registers P/G/c0 and the sign bits; stage 2 resolves the carries
// with cla8_carry and registers sum and flags.
// Optional feature macro: CLA_ADDSUB_SAT_EN (signed saturation on overflow).
// ---------------------------------------------------------------------------
module cla_addsub_pipe
  import cla_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  input  logic        cin,
  input  logic        sub,
  input  logic        sat,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  sum,
  output logic [3:0]  flags
);

  logic              s1_valid;
  s1_bundle_t        s1_q;
  s1_bundle_t        s1_d;
  logic              s1_adv;
  logic              s2_adv;
  logic [DATA_W-1:0] b_eff;
  logic [DATA_W:1]   carry;
  logic [DATA_W-1:0] raw_sum;
  logic [DATA_W-1:0] fin_sum;
  logic              v_flag;
  logic [3:0]        flags_d;

`ifndef CLA_ADDSUB_SAT_EN
  // sat has no function in this build; tie it off so it is visibly unused.
  logic unused_sat;
  assign unused_sat = sat;
`endif

  // Handshake: a stage advances when its successor can take its contents.
  always_comb begin
    s2_adv   = !out_valid || out_ready;
    s1_adv   = !s1_valid || s2_adv;
    in_ready = s1_adv;
  end

  // Stage-1 next bundle: subtract is a + ~b + 1.
  always_comb begin
    b_eff    = sub ? ~b : b;
    s1_d     = '0;
    s1_d.p     = a ^ b_eff;
    s1_d.g     = a & b_eff;
    s1_d.c0    = sub ? 1'b1 : cin;
    s1_d.a_msb = a[DATA_W-1];
    s1_d.b_msb = b_eff[DATA_W-1];
`ifdef CLA_ADDSUB_SAT_EN
    s1_d.sat   = sat;
`endif
  end

  // Stage-1 register; holds its bundle while stage 2 is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_q <= s1_d;
      end
    end
  end

  cla8_carry u_carry (
    .p  (s1_q.p),
    .g  (s1_q.g),
    .c0 (s1_q.c0),
    .c  (carry)
  );

  // Stage-2 result: sum bits, overflow, optional saturation, flags.
  always_comb begin
    // The msb propagate term equals a_msb ^ b_msb, taken from the sign bits.
    raw_sum = {s1_q.a_msb ^ s1_q.b_msb ^ carry[DATA_W-1],
               s1_q.p[DATA_W-2:0] ^ {carry[DATA_W-2:1], s1_q.c0}};
    v_flag  = carry[DATA_W] ^ carry[DATA_W-1];
`ifdef CLA_ADDSUB_SAT_EN
    // Overflow direction follows the sign of a.
    if (s1_q.sat && v_flag) begin
      fin_sum = s1_q.a_msb ? SAT_NEG : SAT_POS;
    end else begin
      fin_sum = raw_sum;
    end
`else
    fin_sum = raw_sum;
`endif
    flags_d         = 4'b0000;
    flags_d[FLAG_C] = carry[DATA_W];
    flags_d[FLAG_V] = v_flag;
    flags_d[FLAG_Z] = (fin_sum == 8'h00);
    flags_d[FLAG_N] = fin_sum[DATA_W-1];
  end

  // Stage-2 output register; holds sum/flags while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      sum       <= 8'h00;
      flags     <= 4'b0000;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        sum   <= fin_sum;
        flags <= flags_d;
      end
    end
  end

endmodule

// File: tb/tb_cla_addsub_pipe.sv
// ---------------------------------------------------------------------------
// tb_cla_addsub_pipe
// Self-checking bench for cla_addsub_pipe. Inputs change on the falling
// edge; outputs are read 1 ns later. Accepted bundles are pushed through an
// arithmetic reference model into an expected-result queue, and every
// consumed result is compared against the queue head.
// ---------------------------------------------------------------------------
module tb_cla_addsub_pipe;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic       sub;
  logic       sat;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] sum;
  logic [3:0] flags;

  typedef struct {
    logic [7:0] s;
    logic [3:0] f;
  } exp_t;

  exp_t       exp_q[$];
  int         n_tests  = 0;
  int         n_failed = 0;
  int         got_cnt  = 0;
  logic       stall_prev = 1'b0;
  logic [7:0] held_sum   = 8'h00;
  logic [3:0] held_flags = 4'b0000;

  cla_addsub_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .sat       (sat),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .flags     (flags)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: plain unsigned/signed integer arithmetic.
  function automatic exp_t model(input logic [7:0] ta, input logic [7:0] tb_,
                                 input logic tcin, input logic tsub, input logic tsat);
    exp_t r;
    int ua, ub, sa, sb, ures, sres;
    logic c, v;
    ua = int'(ta);
    ub = int'(tb_);
    sa = (ua > 127) ? ua - 256 : ua;
    sb = (ub > 127) ? ub - 256 : ub;
    if (tsub) begin
      ures = ua - ub;
      sres = sa - sb;
      c    = (ua >= ub);
    end else begin
      ures = ua + ub + int'(tcin);
      sres = sa + sb + int'(tcin);
      c    = (ures > 255);
    end
    v   = (sres > 127) || (sres < -128);
    r.s = 8'(ures & 255);
`ifdef CLA_ADDSUB_SAT_EN
    if (tsat && v) r.s = (sa < 0) ? 8'h80 : 8'h7F;
`else
    if (tsat && 1'b0) r.s = 8'h00;
`endif
    r.f = {c, v, (r.s == 8'h00), r.s[7]};
    return r;
  endfunction

  // One clock of stimulus plus scoreboard bookkeeping.
  task automatic step(input logic v, input logic [7:0] ta, input logic [7:0] tb_,
                      input logic tcin, input logic tsub, input logic tsat,
                      input logic ordy, output logic acc);
    exp_t e;
    @(negedge clk);
    in_valid  = v;
    a         = ta;
    b         = tb_;
    cin       = tcin;
    sub       = tsub;
    sat       = tsat;
    out_ready = ordy;
    #1;
    if (stall_prev) begin
      n_tests++;
      if (!out_valid || sum !== held_sum || flags !== held_flags) begin
        n_failed++;
        $display("FAIL stall_hold: got valid=%b sum=%h flags=%b, need valid=1 sum=%h flags=%b",
                 out_valid, sum, flags, held_sum, held_flags);
      end
    end
    if (out_valid && out_ready) begin
      n_tests++;
      got_cnt++;
      if (exp_q.size() == 0) begin
        n_failed++;
        $display("FAIL unexpected_result: got sum=%h flags=%b, need no result", sum, flags);
      end else begin
        e = exp_q.pop_front();
        if (sum !== e.s || flags !== e.f) begin
          n_failed++;
          $display("FAIL result: got sum=%h flags=%b, need sum=%h flags=%b",
                   sum, flags, e.s, e.f);
        end
      end
    end
    acc = in_valid && in_ready;
    if (acc) exp_q.push_back(model(ta, tb_, tcin, tsub, tsat));
    stall_prev = out_valid && !out_ready;
    held_sum   = sum;
    held_flags = flags;
  endtask

  task automatic idle(input logic ordy);
    logic acc;
    step(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, ordy, acc);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && exp_q.size() > 0; i++) idle(1'b1);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_failed++;
      $display("FAIL drain_timeout: got %0d pending, need 0", exp_q.size());
    end
    idle(1'b1);
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_failed++;
      $display("FAIL bubble: got out_valid=%b, need 0", out_valid);
    end
  endtask

  task automatic test_reset();
    in_valid = 1'b0; a = 8'h00; b = 8'h00; cin = 1'b0; sub = 1'b0; sat = 1'b0;
    out_ready = 1'b1;
    rst_n = 1'b0;
    #12;
    n_tests++;
    if (out_valid !== 1'b0 || sum !== 8'h00 || flags !== 4'b0000) begin
      n_failed++;
      $display("FAIL reset_state: got valid=%b sum=%h flags=%b, need 0/00/0000",
               out_valid, sum, flags);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_failed++;
      $display("FAIL reset_in_ready: got %b, need 1", in_ready);
    end
  endtask

  // Single isolated bundle: checks latency and a fixed expected value.
  task automatic run_one(input string name, input logic [7:0] ta, input logic [7:0] tb_,
                         input logic tcin, input logic tsub, input logic tsat,
                         input logic [7:0] es, input logic [3:0] ef);
    logic acc;
    step(1'b1, ta, tb_, tcin, tsub, tsat, 1'b1, acc);
    n_tests++;
    if (!acc) begin
      n_failed++;
      $display("FAIL %s_accept: got accept=0, need 1", name);
    end
    idle(1'b1);
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_failed++;
      $display("FAIL %s_early: got out_valid=%b one edge after accept, need 0", name, out_valid);
    end
    idle(1'b1);
    n_tests++;
    if (out_valid !== 1'b1 || sum !== es || flags !== ef) begin
      n_failed++;
      $display("FAIL %s: got valid=%b sum=%h flags=%b, need valid=1 sum=%h flags=%b",
               name, out_valid, sum, flags, es, ef);
    end
    drain();
  endtask

  task automatic test_directed();
    run_one("add", 8'h3C, 8'h0A, 1'b1, 1'b0, 1'b0, 8'h47, 4'b0000);
    run_one("sub_zero", 8'h55, 8'h55, 1'b0, 1'b1, 1'b0, 8'h00, 4'b1010);
`ifdef CLA_ADDSUB_SAT_EN
    run_one("overflow", 8'h7F, 8'h01, 1'b0, 1'b0, 1'b1, 8'h7F, 4'b0100);
    run_one("neg_sat", 8'h80, 8'h01, 1'b0, 1'b1, 1'b1, 8'h80, 4'b1101);
`else
    run_one("overflow", 8'h7F, 8'h01, 1'b0, 1'b0, 1'b1, 8'h80, 4'b0101);
    run_one("neg_wrap", 8'h80, 8'h01, 1'b0, 1'b1, 1'b1, 8'h7F, 4'b1100);
`endif
    run_one("borrow", 8'h00, 8'h01, 1'b1, 1'b1, 1'b0, 8'hFF, 4'b0001);
    run_one("carry_out", 8'hFF, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 4'b1010);
  endtask

  task automatic test_backpressure();
    logic [7:0] va [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic [7:0] vb [4] = '{8'h01, 8'h02, 8'h03, 8'h04};
    logic acc;
    int idx = 0;
    int start_got = got_cnt;
    for (int cyc = 0; cyc < 30 && idx < 4; cyc++) begin
      step(1'b1, va[idx], vb[idx], 1'b0, 1'b0, 1'b0, (cyc >= 3), acc);
      if (cyc == 2) begin
        n_tests++;
        if (in_ready !== 1'b0) begin
          n_failed++;
          $display("FAIL bp_in_ready: got %b with both stages full, need 0", in_ready);
        end
      end
      if (acc) idx++;
    end
    drain();
    n_tests++;
    if (got_cnt - start_got != 4) begin
      n_failed++;
      $display("FAIL bp_count: got %0d results, need 4", got_cnt - start_got);
    end
  endtask

  task automatic test_random_stream();
    logic acc;
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, 8'($urandom), 8'($urandom), 1'($urandom),
           1'($urandom), 1'($urandom), $urandom_range(0, 3) != 0, acc);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    logic acc;
    int start_got = got_cnt;
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'b1, acc);
      n_tests++;
      if (!acc) begin
        n_failed++;
        $display("FAIL b2b_accept: got accept=0 at bundle %0d, need 1", i);
      end
    end
    drain();
    n_tests++;
    if (got_cnt - start_got != 20) begin
      n_failed++;
      $display("FAIL b2b_count: got %0d results, need 20", got_cnt - start_got);
    end
  endtask

  task automatic test_reset_midstream();
    logic acc;
    step(1'b1, 8'h12, 8'h34, 1'b0, 1'b0, 1'b0, 1'b0, acc);
    step(1'b1, 8'h56, 8'h07, 1'b0, 1'b1, 1'b0, 1'b0, acc);
    idle(1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (out_valid !== 1'b0 || sum !== 8'h00 || flags !== 4'b0000 || in_ready !== 1'b1) begin
      n_failed++;
      $display("FAIL midreset: got valid=%b sum=%h flags=%b rdy=%b, need 0/00/0000/1",
               out_valid, sum, flags, in_ready);
    end
    exp_q.delete();
    stall_prev = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      idle(1'b1);
      n_tests++;
      if (out_valid !== 1'b0) begin
        n_failed++;
        $display("FAIL stale_after_reset: got out_valid=%b at cycle %0d, need 0", out_valid, i);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_random_stream();
    test_reset_midstream();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
    $finish;
  end

endmodule
